// File: rtl/alu_pkg.sv
// Shared ALU control encodings and RV32 decode constants for the
// multi-cycle ALU issue path.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_ctl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and result handshake bundle between decode and the ALU sequencer.
interface alu_op_sequencer_if;

    logic                      in_valid;
    logic                      in_ready;
    logic [alu_pkg::XLEN-1:0]  instr;
    logic [alu_pkg::XLEN-1:0]  rs1_val;
    logic [alu_pkg::XLEN-1:0]  rs2_val;
    logic [alu_pkg::XLEN-1:0]  imm;
    logic                      res_valid;
    logic                      res_ready;
    logic [alu_pkg::XLEN-1:0]  res_data;
    logic                      res_taken;
    logic                      res_illegal;

    modport master (
        output in_valid, instr, rs1_val, rs2_val, imm, res_ready,
        input  in_ready, res_valid, res_data, res_taken, res_illegal
    );

    modport slave (
        input  in_valid, instr, rs1_val, rs2_val, imm, res_ready,
        output in_ready, res_valid, res_data, res_taken, res_illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational translation of opcode/funct3/funct7[5] into ALU control,
// operand-B select and branch qualifiers.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output alu_ctl_t        alu_ctl,
    output logic            use_imm,
    output logic            is_branch,
    output logic            branch_ne,
    output logic            illegal
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       instr_unused_s;

    assign opcode_s       = instr[6:0];
    assign funct3_s       = instr[14:12];
    assign instr_unused_s = ^{instr[31], instr[29:15], instr[11:7]};

    // Opcode / funct3 decode table
    always_comb begin
        alu_ctl   = ALU_ADD;
        use_imm   = 1'b0;
        is_branch = 1'b0;
        branch_ne = 1'b0;
        illegal   = 1'b0;
        case (opcode_s)
            OP_R: begin
                case (funct3_s)
                    F3_ADD_SUB: alu_ctl = instr[30] ? ALU_SUB : ALU_ADD;
                    F3_AND:     alu_ctl = ALU_AND;
                    F3_OR:      alu_ctl = ALU_OR;
                    F3_SLT:     alu_ctl = ALU_SLT;
                    default:    illegal = 1'b1;
                endcase
            end
            OP_I: begin
                use_imm = 1'b1;
                case (funct3_s)
                    F3_ADD_SUB: alu_ctl = ALU_ADD;
                    F3_AND:     alu_ctl = ALU_AND;
                    F3_OR:      alu_ctl = ALU_OR;
                    F3_SLT:     alu_ctl = ALU_SLT;
                    default:    illegal = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                use_imm = 1'b1;
                alu_ctl = ALU_ADD;
            end
            OP_BRANCH: begin
                alu_ctl   = ALU_SUB;
                is_branch = 1'b1;
                case (funct3_s)
                    F3_BEQ:  branch_ne = 1'b0;
                    F3_BNE:  branch_ne = 1'b1;
                    default: illegal   = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU issue FSM: accept a decoded request, drive the ALU for a
// programmable settle time, capture the result and hold it until accepted.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
)(
    input  logic                     clk,
    input  logic                     rst_n,
    alu_op_sequencer_if.slave        bus,
    output logic [3:0]               alu_ctl,
    output logic [XLEN-1:0]          alu_a,
    output logic [XLEN-1:0]          alu_b,
    input  logic [XLEN-1:0]          alu_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    alu_ctl_t         dec_ctl_s;
    logic             dec_use_imm_s;
    logic             dec_is_branch_s;
    logic             dec_branch_ne_s;
    logic             dec_illegal_s;

    logic [1:0]       state_r;
    logic [3:0]       cnt_r;
    alu_ctl_t         alu_ctl_r;
    logic [XLEN-1:0]  alu_a_r;
    logic [XLEN-1:0]  alu_b_r;
    logic             is_branch_r;
    logic             branch_ne_r;
    logic [XLEN-1:0]  res_data_r;
    logic             res_taken_r;
    logic             res_illegal_r;
    logic             in_ready_r;
    logic             res_valid_r;

    alu_op_decode u_decode (
        .instr     (bus.instr),
        .alu_ctl   (dec_ctl_s),
        .use_imm   (dec_use_imm_s),
        .is_branch (dec_is_branch_s),
        .branch_ne (dec_branch_ne_s),
        .illegal   (dec_illegal_s)
    );

    // Issue FSM, settle counter, operand launch and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            alu_ctl_r     <= ALU_AND;
            alu_a_r       <= {XLEN{1'b0}};
            alu_b_r       <= {XLEN{1'b0}};
            is_branch_r   <= 1'b0;
            branch_ne_r   <= 1'b0;
            res_data_r    <= {XLEN{1'b0}};
            res_taken_r   <= 1'b0;
            res_illegal_r <= 1'b0;
            in_ready_r    <= 1'b1;
            res_valid_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        if (dec_illegal_s) begin
                            // Illegal ops skip the ALU entirely and report at once
                            state_r       <= ST_HOLD;
                            res_data_r    <= {XLEN{1'b0}};
                            res_taken_r   <= 1'b0;
                            res_illegal_r <= 1'b1;
                            res_valid_r   <= 1'b1;
                        end else begin
                            state_r     <= ST_DRIVE;
                            cnt_r       <= CNT_LOAD;
                            alu_ctl_r   <= dec_ctl_s;
                            alu_a_r     <= bus.rs1_val;
                            alu_b_r     <= dec_use_imm_s ? bus.imm : bus.rs2_val;
                            is_branch_r <= dec_is_branch_s;
                            branch_ne_r <= dec_branch_ne_s;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        state_r       <= ST_HOLD;
                        res_data_r    <= alu_out;
                        res_taken_r   <= is_branch_r &
                                         (branch_ne_r ? (alu_out != {XLEN{1'b0}})
                                                      : (alu_out == {XLEN{1'b0}}));
                        res_illegal_r <= 1'b0;
                        res_valid_r   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        state_r     <= ST_IDLE;
                        res_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        res_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    res_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign alu_ctl         = alu_ctl_r;
    assign alu_a           = alu_a_r;
    assign alu_b           = alu_b_r;
    assign bus.in_ready    = in_ready_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_data    = res_data_r;
    assign bus.res_taken   = res_taken_r;
    assign bus.res_illegal = res_illegal_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: one instance with a 1-cycle settle
// time and one with a 3-cycle settle time, each driving a behavioural ALU.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        taken;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] im;
        logic [3:0]  ctl;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid_a  [2];
    logic        res_ready_a [2];
    logic [31:0] instr_a     [2];
    logic [31:0] rs1_a       [2];
    logic [31:0] rs2_a       [2];
    logic [31:0] imm_a       [2];
    logic        in_ready_a  [2];
    logic        res_valid_a [2];
    logic [31:0] res_data_a  [2];
    logic        res_taken_a [2];
    logic        res_illegal_a [2];
    logic [3:0]  alu_ctl_a   [2];
    logic [31:0] alu_a_a     [2];
    logic [31:0] alu_b_a     [2];
    logic [31:0] alu_out_a   [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];

    alu_op_sequencer_if bus0 ();
    alu_op_sequencer_if bus1 ();

    assign bus0.in_valid  = in_valid_a[0];
    assign bus0.instr     = instr_a[0];
    assign bus0.rs1_val   = rs1_a[0];
    assign bus0.rs2_val   = rs2_a[0];
    assign bus0.imm       = imm_a[0];
    assign bus0.res_ready = res_ready_a[0];
    assign in_ready_a[0]    = bus0.in_ready;
    assign res_valid_a[0]   = bus0.res_valid;
    assign res_data_a[0]    = bus0.res_data;
    assign res_taken_a[0]   = bus0.res_taken;
    assign res_illegal_a[0] = bus0.res_illegal;

    assign bus1.in_valid  = in_valid_a[1];
    assign bus1.instr     = instr_a[1];
    assign bus1.rs1_val   = rs1_a[1];
    assign bus1.rs2_val   = rs2_a[1];
    assign bus1.imm       = imm_a[1];
    assign bus1.res_ready = res_ready_a[1];
    assign in_ready_a[1]    = bus1.in_ready;
    assign res_valid_a[1]   = bus1.res_valid;
    assign res_data_a[1]    = bus1.res_data;
    assign res_taken_a[1]   = bus1.res_taken;
    assign res_illegal_a[1] = bus1.res_illegal;

    alu_op_sequencer #(.SETTLE_CYCLES(1)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus0),
        .alu_ctl (alu_ctl_a[0]),
        .alu_a   (alu_a_a[0]),
        .alu_b   (alu_b_a[0]),
        .alu_out (alu_out_a[0])
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus1),
        .alu_ctl (alu_ctl_a[1]),
        .alu_a   (alu_a_a[1]),
        .alu_b   (alu_b_a[1]),
        .alu_out (alu_out_a[1])
    );

    function automatic logic [31:0] alu_fn(logic [3:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out_a[0] = alu_fn(alu_ctl_a[0], alu_a_a[0], alu_b_a[0]);
    assign alu_out_a[1] = alu_fn(alu_ctl_a[1], alu_a_a[1], alu_b_a[1]);

    // Architectural result of one request, independent of ALU encodings
    function automatic exp_t ref_model(logic [31:0] ins, logic [31:0] r1,
                                       logic [31:0] r2, logic [31:0] im);
        exp_t        e;
        logic [31:0] res;
        logic [2:0]  f3;
        e   = '0;
        res = 32'd0;
        f3  = ins[14:12];
        case (ins[6:0])
            7'b0110011, 7'b0010011: begin
                logic [31:0] b;
                b = (ins[6:0] == 7'b0010011) ? im : r2;
                case (f3)
                    3'b000: res = (ins[6:0] == 7'b0110011 && ins[30]) ? r1 - b : r1 + b;
                    3'b111: res = r1 & b;
                    3'b110: res = r1 | b;
                    3'b010: res = ($signed(r1) < $signed(b)) ? 32'd1 : 32'd0;
                    default: e.illegal = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011: res = r1 + im;
            7'b1100011: begin
                res = r1 - r2;
                case (f3)
                    3'b000:  e.taken = (res == 32'd0);
                    3'b001:  e.taken = (res != 32'd0);
                    default: e.illegal = 1'b1;
                endcase
            end
            default: e.illegal = 1'b1;
        endcase
        if (e.illegal) begin
            e.taken = 1'b0;
            e.data  = 32'd0;
        end else begin
            e.data = res;
        end
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic compare_res(int s);
        exp_t e;
        int   sz;
        sz = (s == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            check("unexpected_res", 32'd1, 32'd0);
        end else begin
            e = (s == 0) ? q0.pop_front() : q1.pop_front();
            check("res_data",    res_data_a[s], e.data);
            check("res_taken",   32'(res_taken_a[s]), 32'(e.taken));
            check("res_illegal", 32'(res_illegal_a[s]), 32'(e.illegal));
        end
    endtask

    // Result monitor: a transfer completes at the next edge when valid & ready
    always @(negedge clk) begin
        if (rst_n && res_valid_a[0] && res_ready_a[0]) compare_res(0);
        if (rst_n && res_valid_a[1] && res_ready_a[1]) compare_res(1);
    end

    task automatic send(int s, logic [31:0] ins, logic [31:0] r1,
                        logic [31:0] r2, logic [31:0] im);
        int n;
        n = 0;
        while (!in_ready_a[s] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_in_ready", 32'(in_ready_a[s]), 32'd1);
        instr_a[s]    = ins;
        rs1_a[s]      = r1;
        rs2_a[s]      = r2;
        imm_a[s]      = im;
        in_valid_a[s] = 1'b1;
        if (s == 0) q0.push_back(ref_model(ins, r1, r2, im));
        else        q1.push_back(ref_model(ins, r1, r2, im));
        @(posedge clk); #1;
        in_valid_a[s] = 1'b0;
    endtask

    task automatic wait_done(int s);
        int n;
        n = 0;
        while (((s == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("result_timeout", 32'(n < 100), 32'd1);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{32'h00007013, 32'hFF00FF00, 32'd0, 32'h0000FFFF, 4'd0};
        vecs[1] = '{32'h00002033, 32'hFFFFFFFF, 32'd1, 32'd0,        4'd7};
        vecs[2] = '{32'h00000003, 32'h00000100, 32'd0, 32'hFFFFFFFC, 4'd2};
        vecs[3] = '{32'h00002023, 32'h00000200, 32'd0, 32'd8,        4'd2};
        vecs[4] = '{32'h00001033, 32'd1,        32'd2, 32'd0,        4'hF};
        vecs[5] = '{32'h00004063, 32'd1,        32'd2, 32'd0,        4'hF};
        vecs[6] = '{32'h40000013, 32'd5,        32'd0, 32'd3,        4'd2};
        vecs[7] = '{32'h00006013, 32'h000000F0, 32'd0, 32'h0000000F, 4'd1};

        for (int i = 0; i < 2; i++) begin
            in_valid_a[i]  = 1'b0;
            res_ready_a[i] = 1'b1;
            instr_a[i]     = 32'd0;
            rs1_a[i]       = 32'd0;
            rs2_a[i]       = 32'd0;
            imm_a[i]       = 32'd0;
        end

        repeat (2) @(posedge clk); #1;
        check("rst_in_ready",  32'(in_ready_a[0]), 32'd1);
        check("rst_res_valid", 32'(res_valid_a[0]), 32'd0);
        check("rst_alu_ctl",   32'(alu_ctl_a[0]), 32'd0);
        check("rst_alu_a",     alu_a_a[0], 32'd0);
        check("rst_res_data",  res_data_a[0], 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // R-type SUB, settle 1
        send(0, 32'h40208033, 32'd10, 32'd3, 32'd0);
        check("sub_alu_ctl", 32'(alu_ctl_a[0]), 32'd6);
        check("sub_alu_a",   alu_a_a[0], 32'd10);
        check("sub_alu_b",   alu_b_a[0], 32'd3);
        check("sub_busy",    32'(in_ready_a[0]), 32'd0);
        @(posedge clk); #1;
        check("sub_res_valid", 32'(res_valid_a[0]), 32'd1);
        check("sub_res_data",  res_data_a[0], 32'd7);
        @(posedge clk); #1;
        check("sub_in_ready_back", 32'(in_ready_a[0]), 32'd1);
        check("sub_res_valid_low", 32'(res_valid_a[0]), 32'd0);

        // ADDI wrap-around
        send(0, 32'h00000013, 32'hFFFFFFFF, 32'd0, 32'd1);
        check("addi_alu_ctl", 32'(alu_ctl_a[0]), 32'd2);
        check("addi_alu_b",   alu_b_a[0], 32'd1);
        wait_done(0);

        // BEQ then BNE on equal operands
        send(0, 32'h00000063, 32'h1234, 32'h1234, 32'd0);
        check("beq_alu_ctl", 32'(alu_ctl_a[0]), 32'd6);
        wait_done(0);
        send(0, 32'h00001063, 32'h1234, 32'h1234, 32'd0);
        check("bne_alu_ctl", 32'(alu_ctl_a[0]), 32'd6);
        wait_done(0);

        // Illegal opcode with in_valid held and the result back-pressured
        res_ready_a[0] = 1'b0;
        instr_a[0]     = 32'h0000007F;
        rs1_a[0]       = 32'hDEADBEEF;
        in_valid_a[0]  = 1'b1;
        q0.push_back(ref_model(32'h0000007F, 32'hDEADBEEF, 32'd0, 32'd0));
        @(posedge clk); #1;
        check("ill_res_valid", 32'(res_valid_a[0]), 32'd1);
        check("ill_flag",      32'(res_illegal_a[0]), 32'd1);
        check("ill_res_data",  res_data_a[0], 32'd0);
        check("ill_alu_ctl",   32'(alu_ctl_a[0]), 32'd6);
        check("ill_alu_a",     alu_a_a[0], 32'h1234);
        repeat (2) @(posedge clk); #1;
        check("ill_no_accept", 32'(in_ready_a[0]), 32'd0);
        check("ill_hold",      32'(res_valid_a[0]), 32'd1);
        in_valid_a[0]  = 1'b0;
        res_ready_a[0] = 1'b1;
        @(posedge clk); #1;
        check("ill_idle",  32'(in_ready_a[0]), 32'd1);
        check("ill_drain", 32'(q0.size()), 32'd0);

        // Mixed legal and illegal requests
        for (int i = 0; i < 8; i++) begin
            send(0, vecs[i].ins, vecs[i].r1, vecs[i].r2, vecs[i].im);
            if (vecs[i].ctl != 4'hF) check("vec_alu_ctl", 32'(alu_ctl_a[0]), 32'(vecs[i].ctl));
            wait_done(0);
        end

        // Backpressure, settle 3
        res_ready_a[1] = 1'b0;
        send(1, 32'h00006033, 32'h000000F0, 32'h0000000F, 32'd0);
        check("bp_alu_ctl", 32'(alu_ctl_a[1]), 32'd1);
        @(posedge clk); #1;
        check("bp_wait1", 32'(res_valid_a[1]), 32'd0);
        @(posedge clk); #1;
        check("bp_wait2", 32'(res_valid_a[1]), 32'd0);
        @(posedge clk); #1;
        check("bp_capture", 32'(res_valid_a[1]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(res_valid_a[1]), 32'd1);
            check("bp_hold_data",  res_data_a[1], 32'h000000FF);
            check("bp_hold_busy",  32'(in_ready_a[1]), 32'd0);
        end
        res_ready_a[1] = 1'b1;
        @(posedge clk); #1;
        check("bp_idle",  32'(in_ready_a[1]), 32'd1);
        check("bp_drain", 32'(q1.size()), 32'd0);

        // Reset one edge into DRIVE
        send(1, 32'h40208033, 32'd20, 32'd5, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        q1.delete();
        #1;
        check("mid_rst_alu_ctl",   32'(alu_ctl_a[1]), 32'd0);
        check("mid_rst_alu_a",     alu_a_a[1], 32'd0);
        check("mid_rst_alu_b",     alu_b_a[1], 32'd0);
        check("mid_rst_res_data",  res_data_a[1], 32'd0);
        check("mid_rst_taken",     32'(res_taken_a[1]), 32'd0);
        check("mid_rst_illegal",   32'(res_illegal_a[1]), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid_a[1]), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready_a[1]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_res", 32'(res_valid_a[1]), 32'd0);
        end
        send(1, 32'h00000033, 32'd5, 32'd7, 32'd0);
        wait_done(1);

        check("final_q0_empty", 32'(q0.size()), 32'd0);
        check("final_q1_empty", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
